// File: rtl/julia_pkg.sv
// Shared widths, escape threshold and FSM encoding for the Julia escape-time engine.
// Components are signed Q4.14, so products are Q8.28 and |z|^2 >= 4 compares against 4<<28.
package julia_pkg;

    localparam int DW     = 18;
    localparam int FRAC   = 14;
    localparam int ITER_W = 8;
    localparam int XW     = 10;
    localparam int YW     = 9;

    localparam logic signed [2*DW:0] ESC_THRESH = (2*DW+1)'(4) << (2*FRAC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/julia_cmul_step.sv
// One combinational Julia step: next z = z^2 + c, plus the |z|^2 >= 4 escape flag.
// Products are kept at full precision; the new z wraps to DW bits without saturation.
module julia_cmul_step
    import julia_pkg::*;
(
    input  logic signed [DW-1:0] zr,
    input  logic signed [DW-1:0] zi,
    input  logic signed [DW-1:0] cr,
    input  logic signed [DW-1:0] ci,
    output logic signed [DW-1:0] zr_next,
    output logic signed [DW-1:0] zi_next,
    output logic                 esc
);

    logic signed [2*DW-1:0] p_rr;
    logic signed [2*DW-1:0] p_ii;
    logic signed [2*DW-1:0] p_ri;
    logic signed [2*DW:0]   mag;
    logic signed [2*DW:0]   diff;
    logic signed [2*DW:0]   dbl;

    assign p_rr = zr * zr;
    assign p_ii = zi * zi;
    assign p_ri = zr * zi;

    // One extra bit so the sum of two squares and the doubled cross term cannot overflow
    assign mag  = (2*DW+1)'(p_rr) + (2*DW+1)'(p_ii);
    assign diff = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
    assign dbl  = {p_ri, 1'b0};

    assign esc     = (mag >= ESC_THRESH);
    assign zr_next = DW'(diff >>> FRAC) + cr;
    assign zi_next = DW'(dbl >>> FRAC) + ci;

endmodule

// File: rtl/julia_iter_engine.sv
// Per-pixel escape-time iterator: accepts a pixel and z0, iterates z <- z^2 + c,
// and returns the escape count with the pixel address over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a pixel; latches address, z0 and limit on in_valid
// ITER  | one z update per cycle until escape or count reaches the limit
// DONE  | result presented and held until out_ready
module julia_iter_engine
    import julia_pkg::*;
(
    input  logic                     clk_50,
    input  logic                     reset,
    input  logic signed [DW-1:0]     c_re,
    input  logic signed [DW-1:0]     c_im,
    input  logic        [ITER_W-1:0] max_iter,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [XW-1:0]     in_x,
    input  logic        [YW-1:0]     in_y,
    input  logic signed [DW-1:0]     in_zre,
    input  logic signed [DW-1:0]     in_zim,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [XW-1:0]     out_x,
    output logic        [YW-1:0]     out_y,
    output logic        [ITER_W-1:0] out_iter,
    output logic                     busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic signed [DW-1:0]   zr;
    logic signed [DW-1:0]   zi;
    logic signed [DW-1:0]   zr_nxt;
    logic signed [DW-1:0]   zi_nxt;
    logic                   esc;
    logic                   finish_hit;
    logic [ITER_W-1:0]      cnt;
    logic [ITER_W-1:0]      lim;
    logic [XW-1:0]          px;
    logic [YW-1:0]          py;

    julia_cmul_step u_step (
        .zr      (zr),
        .zi      (zi),
        .cr      (c_re),
        .ci      (c_im),
        .zr_next (zr_nxt),
        .zi_next (zi_nxt),
        .esc     (esc)
    );

    // Escape is tested before the limit and before any update, so a count of
    // max_iter is reported without ever incrementing past it.
    assign finish_hit = esc || (cnt == lim);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (finish_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            zr       <= '0;
            zi       <= '0;
            cnt      <= '0;
            lim      <= '0;
            px       <= '0;
            py       <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_iter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        zr  <= in_zre;
                        zi  <= in_zim;
                        px  <= in_x;
                        py  <= in_y;
                        lim <= max_iter;
                        cnt <= '0;
                    end
                end
                ITER: begin
                    if (finish_hit) begin
                        out_iter <= cnt;
                        out_x    <= px;
                        out_y    <= py;
                    end else begin
                        zr  <= zr_nxt;
                        zi  <= zi_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_julia_iter_engine.sv
// Bench for julia_iter_engine: directed vector table, reset/backpressure sequences,
// and random pixels checked against an arithmetic escape-time model.
module tb_julia_iter_engine;
    import julia_pkg::*;

    logic                     clk_50 = 1'b0;
    logic                     reset;
    logic signed [DW-1:0]     c_re, c_im, in_zre, in_zim;
    logic        [ITER_W-1:0] max_iter, out_iter;
    logic                     in_valid, in_ready, out_valid, out_ready, busy;
    logic        [XW-1:0]     in_x, out_x;
    logic        [YW-1:0]     in_y, out_y;

    int errors = 0;
    int checks = 0;

    julia_iter_engine dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .c_re      (c_re),
        .c_im      (c_im),
        .max_iter  (max_iter),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_zre    (in_zre),
        .in_zim    (in_zim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_iter  (out_iter),
        .busy      (busy)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {
        int zre, zim, cre, cim, mi, x, y, hold, exp_iter;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap18(input longint v);
        longint r;
        r = v & 64'h3FFFF;
        if (r >= 64'h20000) r = r - 64'h40000;
        return r;
    endfunction

    // Escape-time reference in plain integer arithmetic on Q4.14 values
    function automatic int model_iter(input int zre, zim, cre, cim, mi);
        longint zr, zi, rr, ii, nr, ni;
        zr = zre;
        zi = zim;
        for (int n = 0; n <= 255; n++) begin
            rr = zr * zr;
            ii = zi * zi;
            if (rr + ii >= (longint'(4) <<< 28) || n == mi) return n;
            nr = wrap18(((rr - ii) >>> 14) + cre);
            ni = wrap18(((2 * zr * zi) >>> 14) + cim);
            zr = nr;
            zi = ni;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk_50);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk_50);
        reset = 1'b1;
    endtask

    task automatic run_pixel(input int zre, zim, cre, cim, mi, xx, yy, hold,
                             output int got_iter, got_x, got_y, lat, output bit ok);
        bit stable;
        ok = 1'b0;
        got_iter = -1; got_x = -1; got_y = -1; lat = 0;
        @(negedge clk_50);
        check("in_ready_idle", longint'(in_ready), 1);
        c_re = DW'(cre); c_im = DW'(cim);
        in_zre = DW'(zre); in_zim = DW'(zim);
        max_iter = ITER_W'(mi);
        in_x = XW'(xx); in_y = YW'(yy);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk_50); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk_50); #1;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL timeout: got no out_valid within 400 cycles expected a result");
            do_reset();
            return;
        end
        got_iter = int'(out_iter); got_x = int'(out_x); got_y = int'(out_y);
        stable = 1'b1;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_x = ~in_x; in_y = ~in_y; in_zre = '0; in_zim = '0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_50); #1;
                if (out_iter != ITER_W'(got_iter) || out_x != XW'(got_x) || out_y != YW'(got_y)
                    || in_ready || !out_valid || !busy) stable = 1'b0;
            end
            in_valid = 1'b0;
            check("held_stable", longint'(stable), 1);
        end
        out_ready = 1'b1;
        @(posedge clk_50); #1;
        check("valid_drop", longint'(out_valid), 0);
        check("back_idle", longint'(in_ready), 1);
        @(posedge clk_50); #1;
        out_ready = 1'b0;
        check("single_handshake", longint'(out_valid), 0);
    endtask

    vec_t vt[$];

    initial begin
        int gi, gx, gy, lat, seen;
        bit ok;

        vt.push_back('{zre: 0,       zim: 0, cre: 0,       cim: 0,       mi: 20,  x: 5,    y: 7,   hold: 0,  exp_iter: 20});
        vt.push_back('{zre: 'h8000,  zim: 0, cre: 'h1234,  cim: -'h3000, mi: 100, x: 1,    y: 2,   hold: 0,  exp_iter: 0});
        vt.push_back('{zre: 0,       zim: 0, cre: 'h4000,  cim: 0,       mi: 50,  x: 3,    y: 4,   hold: 0,  exp_iter: 2});
        vt.push_back('{zre: 0,       zim: 0, cre: 'h4000,  cim: 0,       mi: 50,  x: 639,  y: 479, hold: 10, exp_iter: 2});
        vt.push_back('{zre: 0,       zim: 0, cre: 0,       cim: 0,       mi: 0,   x: 11,   y: 12,  hold: 0,  exp_iter: 0});
        vt.push_back('{zre: 0,       zim: 0, cre: 0,       cim: 0,       mi: 255, x: 1023, y: 511, hold: 2,  exp_iter: 255});
        vt.push_back('{zre: 'h7FFF,  zim: 0, cre: 0,       cim: 0,       mi: 10,  x: 20,   y: 30,  hold: 1,  exp_iter: 1});

        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        c_re = '0; c_im = '0; in_zre = '0; in_zim = '0;
        max_iter = '0; in_x = '0; in_y = '0;
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_iter", longint'(out_iter), 0);
        check("rst_out_xy", longint'({out_x, out_y}), 0);
        repeat (3) @(negedge clk_50);
        reset = 1'b1;

        foreach (vt[i]) begin
            run_pixel(vt[i].zre, vt[i].zim, vt[i].cre, vt[i].cim, vt[i].mi,
                      vt[i].x, vt[i].y, vt[i].hold, gi, gx, gy, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_iter", i), gi, vt[i].exp_iter);
                check($sformatf("vec%0d_x", i), gx, vt[i].x);
                check($sformatf("vec%0d_y", i), gy, vt[i].y);
                check($sformatf("vec%0d_latency", i), lat, vt[i].exp_iter + 1);
            end
        end

        // Reset while iterating a non-escaping pixel must drop it silently
        @(negedge clk_50);
        c_re = '0; c_im = '0; in_zre = 18'sh02000; in_zim = '0;
        max_iter = 8'd200; in_x = 10'd100; in_y = 9'd50;
        in_valid = 1'b1;
        @(posedge clk_50); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk_50);
        @(negedge clk_50);
        check("mid_busy_before", longint'(busy), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", longint'(in_ready), 1);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_busy", longint'(busy), 0);
        @(negedge clk_50);
        reset = 1'b1;
        seen = 0;
        repeat (250) begin
            @(posedge clk_50); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);

        for (int r = 0; r < 40; r++) begin
            int zre, zim, cre, cim, mi, xx, yy, hold, exp;
            zre  = int'($urandom_range(0, 81920)) - 40960;
            zim  = int'($urandom_range(0, 81920)) - 40960;
            cre  = int'($urandom_range(0, 64000)) - 32000;
            cim  = int'($urandom_range(0, 64000)) - 32000;
            mi   = int'($urandom_range(0, 60));
            xx   = int'($urandom_range(0, 1023));
            yy   = int'($urandom_range(0, 511));
            hold = int'($urandom_range(0, 3));
            exp  = model_iter(zre, zim, cre, cim, mi);
            run_pixel(zre, zim, cre, cim, mi, xx, yy, hold, gi, gx, gy, lat, ok);
            if (ok) begin
                check($sformatf("rnd%0d_iter", r), gi, exp);
                check($sformatf("rnd%0d_xy", r), (gx << 9) | gy, (xx << 9) | yy);
                check($sformatf("rnd%0d_latency", r), lat, exp + 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/julia_iter_engine.md
Name: julia_iter_engine

Overview:
- Per-pixel escape-time iteration unit for the Julia set renderer.
- Sits between the pixel coordinate scanner upstream and the VGA frame-buffer writer downstream.
- Accepts one pixel (screen address plus starting z) per transaction and iterates z <- z^2 + c in signed fixed point.
- Returns the escape iteration count with the pixel address over a valid/ready handshake.

Parameters:
- DW, 18: data width of every complex component, signed Q4.14 (matches 18x18 hard multipliers).
- FRAC, 14: fractional bits; must be DW-4.
- ITER_W, 8: width of iteration count and max_iter.
- XW, 10: pixel x address width.
- YW, 9: pixel y address width.

Ports:
- clk_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- c_re  in  DW  real part of c, Q4.14; must be stable while busy=1.
- c_im  in  DW  imaginary part of c, Q4.14; must be stable while busy=1.
- max_iter  in  ITER_W  iteration limit, sampled at acceptance.
- in_valid  in  1  upstream pixel offered.
- in_ready  out  1  engine can accept a pixel.
- in_x  in  XW  pixel column.
- in_y  in  YW  pixel row.
- in_zre  in  DW  z0 real part.
- in_zim  in  DW  z0 imaginary part.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes result.
- out_x  out  XW  pixel column of result.
- out_y  out  YW  pixel row of result.
- out_iter  out  ITER_W  escape count.
- busy  out  1  high in ITER or DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE. in_ready=1, out_valid=0, busy=0; out_x, out_y, out_iter, internal z and count all 0. Any in-flight pixel is discarded with no output.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch x, y, z=(in_zre,in_zim), lim=max_iter; count=0; go to ITER.
- ITER, each cycle:
  - Compute with combinational multipliers: p_rr=zr*zr, p_ii=zi*zi, p_ri=zr*zi, each 2*DW signed (Q8.28).
  - mag = p_rr+p_ii, 2*DW+1 bits, full precision.
  - esc = (mag >= 4<<(2*FRAC)).
  - If esc or count==lim: out_iter=count, out_x/out_y=latched address; go to DONE.
  - Else: zr <= ((p_rr-p_ii)>>>FRAC)+c_re and zi <= ((p_ri<<1)>>>FRAC)+c_im, both truncated to DW bits (wrap, no saturation); count++.
- Escape test always takes priority over the update. The escape test is the first check, so z0 already outside radius 2 returns 0.
- DONE:
  - out_valid=1; outputs held stable until out_ready=1.
  - On out_ready=1: go to IDLE.
  - out_valid deasserts on the next cycle.
- Latency: for result n, out_valid rises n+1 clock edges after the acceptance edge.
- Throughput: 1 pixel per n+3 cycles minimum.
- Boundary conditions:
  - max_iter=0: result 0 after 1 ITER cycle.
  - max_iter=2^ITER_W-1: count never wraps because the limit test precedes increment.
- Contract: |c_re|, |c_im| < 2.0. Violations may wrap but must not hang the FSM, since count still terminates.
- in_ready=0 in ITER and DONE; in_valid is ignored there and upstream holds its data.
- out_ready while not DONE: ignored.

Decomposition:
- Package julia_pkg: DW, FRAC, ITER_W, XW, YW, the ESC_THRESH constant (4<<(2*FRAC)), and the state enum encoding (IDLE=0, ITER=1, DONE=2).
- One natural sub-module: julia_cmul_step. Combinational; takes z and c, produces next z and the esc flag.
- FSM, handshake and count live in julia_iter_engine.

Test Plan:
- Reset mid-ITER: c=(0,0), z0=(0.5,0), max_iter=200, assert reset=0 after 5 cycles -> in_ready=1, out_valid=0 immediately, and no result is ever produced for that pixel.
- Never escapes: c=(0,0), z0=(0,0), max_iter=20 -> out_iter=20; out_valid rises 21 edges after acceptance.
- Immediate escape: z0=(2.0,0) (0x08000), any c -> out_iter=0; out_valid 1 edge after acceptance, exactly at threshold.
- Escape at count 2: c=(1.0,0), z0=(0,0), max_iter=50 -> z sequence 0, 1, 2, with mag 4.0 at count 2 -> out_iter=2.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with x=639, y=479 -> out_x=639, out_y=479 and out_iter held stable, in_ready=0 throughout. Release -> one handshake, then IDLE.
- Boundary limit: max_iter=0 with c=(0,0), z0=(0,0) -> out_iter=0. max_iter=255 with c=(0,0), z0=(0,0) -> out_iter=255, no wrap.
